// File: rtl/lut_neuron_cfg.sv
// lut_neuron_cfg -- loadable lookup-table neuron.
//
// A DEPTH = 2**IN_BITS entry table of OUT_BITS-wide values is streamed in over
// the cfg_* port. Once a correctly framed load completes, the block answers
// lookups on the in_*/out_* ports with a one-cycle latency.
//
// Ports
//   clk, rst        sole clock; synchronous active-high reset
//   cfg_valid/ready load-entry handshake (ready high in EMPTY and LOAD)
//   cfg_data        entry written at the current write pointer
//   cfg_last        marks the final entry of a load
//   cfg_clear       one-cycle pulse: drop table, in-flight result, go to EMPTY
//   cfg_done        high while the table is loaded (RUN)
//   cfg_err         sticky load-framing error
//   in_valid/ready  lookup request handshake, in_data = lookup address
//   out_valid/ready lookup result handshake, out_data = table entry
//   dbg_state       current FSM state (EMPTY=0, LOAD=1, RUN=2)
//   rb_addr/rb_data registered table readback, present only when the macro
//                   LUT_NEURON_CFG_READBACK_EN is defined
//
// Handshake semantics (all three ports): a transfer happens on a rising edge
// where valid and ready are both high. A producer holding valid high keeps its
// payload stable until the transfer; out_valid/out_data are held while
// out_ready is low. ready may depend combinationally on the partner's ready
// (in_ready uses out_ready) but never on the same port's valid.

module lut_neuron_cfg #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
`ifdef LUT_NEURON_CFG_READBACK_EN
  input  logic [IN_BITS-1:0]  rb_addr,
  output logic [OUT_BITS-1:0] rb_data,
`endif
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [OUT_BITS-1:0] cfg_data,
  input  logic                cfg_last,
  input  logic                cfg_clear,
  output logic                cfg_done,
  output logic                cfg_err,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
  output logic [1:0]          dbg_state
);

  localparam int DEPTH = 2**IN_BITS;
  localparam logic [IN_BITS-1:0] LAST_ADDR = IN_BITS'(DEPTH - 1);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  logic [1:0]          state;
  logic [IN_BITS-1:0]  wptr;
  logic [OUT_BITS-1:0] mem [DEPTH];

  logic cfg_fire;
  logic in_fire;
  logic at_end;
  logic frame_ok;

  assign cfg_ready = (state != RUN);
  assign cfg_done  = (state == RUN);
  assign in_ready  = (state == RUN) && (!out_valid || out_ready);
  assign dbg_state = state;

  // cfg_clear overrides any transfer presented in the same cycle.
  assign cfg_fire = cfg_valid && cfg_ready && !cfg_clear;
  assign in_fire  = in_valid && in_ready && !cfg_clear;

  // A load is well framed only when cfg_last coincides with the final address.
  assign at_end   = (wptr == LAST_ADDR);
  assign frame_ok = (cfg_last == at_end);

  // Load FSM. EMPTY is always entered with wptr = 0, so the first entry of a
  // load lands at address 0 without special casing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      wptr    <= '0;
      cfg_err <= 1'b0;
    end else if (cfg_clear) begin
      state <= EMPTY;
      wptr  <= '0;
    end else if (cfg_fire) begin
      // First accepted entry of a new load clears a stale error; a framing
      // error on that same entry re-sets it below.
      if (state == EMPTY) cfg_err <= 1'b0;
      if (!frame_ok) begin
        state   <= EMPTY;
        wptr    <= '0;
        cfg_err <= 1'b1;
      end else if (at_end) begin
        state <= RUN;
        wptr  <= '0;
      end else begin
        state <= LOAD;
        wptr  <= wptr + IN_BITS'(1);
      end
    end
  end

  // Table storage has no reset; its contents only matter after a full load.
  always_ff @(posedge clk) begin
    if (cfg_fire && !rst) mem[wptr] <= cfg_data;
  end

  // One-deep output register: a new lookup may enter in the same cycle the
  // held result is accepted, giving one result per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (cfg_clear) begin
      out_valid <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= mem[in_data];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LUT_NEURON_CFG_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) rb_data <= '0;
    else     rb_data <= mem[rb_addr];
  end
`endif

endmodule

// File: tb/tb_lut_neuron_cfg.sv
// tb_lut_neuron_cfg -- self-checking bench for lut_neuron_cfg (defaults
// IN_BITS=6, OUT_BITS=2). The reference model is a plain array holding what
// was loaded plus a queue of results owed on the output port.

module tb_lut_neuron_cfg;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_data;
  logic       cfg_last;
  logic       cfg_clear;
  logic       cfg_done;
  logic       cfg_err;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic [1:0] dbg_state;
`ifdef LUT_NEURON_CFG_READBACK_EN
  logic [5:0] rb_addr;
  logic [1:0] rb_data;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lut_neuron_cfg #(.IN_BITS(6), .OUT_BITS(2)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef LUT_NEURON_CFG_READBACK_EN
    .rb_addr   (rb_addr),
    .rb_data   (rb_data),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .cfg_clear (cfg_clear),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] ref_tab [64];
  logic       mdl_run = 1'b0;
  logic [1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mdl_run = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_clear();
    cfg_clear = 1'b1;
    @(posedge clk);
    #1;
    cfg_clear = 1'b0;
    mdl_run = 1'b0;
    exp_q.delete();
  endtask

  task automatic load_entry(input logic [1:0] d, input logic last);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    #1;
    check("cfg_ready_load", cfg_ready, 1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  // Streams ref_tab as a correctly framed 64-entry load.
  task automatic load_table();
    for (int i = 0; i < 64; i++) begin
      load_entry(ref_tab[i], i == 63);
      if (i == 0) check("err_clear_on_first", cfg_err, 0);
    end
    check("load_done", cfg_done, 1);
    check("load_err", cfg_err, 0);
    check("load_state", dbg_state, 2);
    mdl_run = 1'b1;
    exp_q.delete();
  endtask

  // One lookup-port cycle, checked against the model before the edge.
  task automatic cycle(input logic iv, input logic [5:0] addr, input logic ordy);
    logic exp_ir;
    in_valid  = iv;
    in_data   = addr;
    out_ready = ordy;
    #1;
    exp_ir = mdl_run && ((exp_q.size() == 0) || ordy);
    check("in_ready", in_ready, exp_ir);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
    if ((exp_q.size() != 0) && ordy) void'(exp_q.pop_front());
    if (iv && exp_ir) exp_q.push_back(ref_tab[addr]);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [5:0] addr;
    logic [1:0] exp;
  } vec_t;
  vec_t vecs [6];

  initial begin
    vecs[0] = '{6'b100010, 2'b10};
    vecs[1] = '{6'd0,  2'd0};
    vecs[2] = '{6'd63, 2'd3};
    vecs[3] = '{6'd13, 2'd1};
    vecs[4] = '{6'd30, 2'd2};
    vecs[5] = '{6'd7,  2'd3};

    rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
    cfg_clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef LUT_NEURON_CFG_READBACK_EN
    rb_addr = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_state", dbg_state, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_cfg_done", cfg_done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;

    // Full load of entry i = i mod 4, then table lookups
    for (int i = 0; i < 64; i++) ref_tab[i] = 2'(i % 4);
    load_table();
    check("run_cfg_ready", cfg_ready, 0);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, vecs[k].addr, 1'b1);
      check("vec_out_valid", out_valid, 1);
      check("vec_out_data", out_data, vecs[k].exp);
      cycle(1'b0, 6'd0, 1'b1);
    end

    // Back-to-back 0..3, then a 3-cycle stall
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 6'(k), 1'b1);
      check("b2b_data", out_data, k);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 6'd9, 1'b0);
      check("stall_data", out_data, 3);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
    end
    cycle(1'b1, 6'd9, 1'b1);
    check("after_stall_data", out_data, 1);
    cycle(1'b0, 6'd0, 1'b1);
    check("drained", out_valid, 0);

    // cfg traffic in RUN is ignored
    cfg_valid = 1'b1; cfg_last = 1'b1; cfg_data = 2'd0;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0; cfg_last = 1'b0;
    check("run_ignore_state", dbg_state, 2);
    check("run_ignore_err", cfg_err, 0);
    cycle(1'b1, 6'd3, 1'b1);
    check("run_ignore_tab", out_data, 3);
    cycle(1'b0, 6'd0, 1'b1);

    // cfg_clear with in_valid and a pending result
    cycle(1'b1, 6'd5, 1'b0);
    cfg_clear = 1'b1; in_valid = 1'b1; in_data = 6'd6; out_ready = 1'b0;
    @(posedge clk);
    #1;
    cfg_clear = 1'b0; in_valid = 1'b0;
    mdl_run = 1'b0;
    exp_q.delete();
    check("clr_out_valid", out_valid, 0);
    check("clr_in_ready", in_ready, 0);
    check("clr_cfg_done", cfg_done, 0);
    check("clr_cfg_err", cfg_err, 0);
    check("clr_state", dbg_state, 0);
    cycle(1'b1, 6'd2, 1'b1);

    // Early cfg_last on entry 10
    for (int i = 0; i <= 10; i++) load_entry(2'(i % 4), i == 10);
    check("early_err", cfg_err, 1);
    check("early_state", dbg_state, 0);
    check("early_ready", cfg_ready, 1);
    @(posedge clk);
    #1;
    check("err_sticky", cfg_err, 1);
    load_table();

    // Missing cfg_last on entry 63
    do_clear();
    for (int i = 0; i < 64; i++) load_entry(2'(i % 4), 1'b0);
    check("late_err", cfg_err, 1);
    check("late_state", dbg_state, 0);
    load_table();
    cycle(1'b1, 6'b100010, 1'b1);
    cycle(1'b0, 6'd0, 1'b1);

    // Reset after 30 entries, then a fresh random load
    do_clear();
    for (int i = 0; i < 30; i++) load_entry(2'(i % 4), 1'b0);
    do_reset();
    check("midload_state", dbg_state, 0);
    check("midload_err", cfg_err, 0);
    check("midload_ready", cfg_ready, 1);
    check("midload_done", cfg_done, 0);
    for (int i = 0; i < 64; i++) ref_tab[i] = 2'($urandom_range(0, 3));
    load_table();

    // Randomized lookup traffic against the model
    for (int n = 0; n < 400; n++)
      cycle(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
            $urandom_range(0, 3) != 0);
    cycle(1'b0, 6'd0, 1'b1);

    // Reset with a result pending
    cycle(1'b1, 6'd4, 1'b0);
    do_reset();
    check("midlookup_valid", out_valid, 0);
    check("midlookup_data", out_data, 0);
    check("midlookup_state", dbg_state, 0);

`ifdef LUT_NEURON_CFG_READBACK_EN
    for (int i = 0; i < 64; i++) ref_tab[i] = 2'(i % 4);
    load_table();
    rb_addr = 6'd63;
    @(posedge clk);
    #1;
    check("rb_63", rb_data, 3);
    rb_addr = 6'd34;
    @(posedge clk);
    #1;
    check("rb_34", rb_data, 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lut_neuron_cfg.md
LUT_NEURON_CFG -- requirements
Module: lut_neuron_cfg

Interface
REQ-001 Parameter IN_BITS, default 6, lookup address width; table depth DEPTH = 2**IN_BITS.
REQ-002 Parameter OUT_BITS, default 2, width of each table entry.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cfg_valid  input  1  table-load entry present.
REQ-006 cfg_ready  output  1  block accepts load entry; high in EMPTY and LOAD.
REQ-007 cfg_data  input  OUT_BITS  entry written at the current write pointer.
REQ-008 cfg_last  input  1  marks the final entry of the load.
REQ-009 cfg_clear  input  1  single-cycle pulse that discards the table and returns to EMPTY.
REQ-010 cfg_done  output  1  high while in RUN.
REQ-011 cfg_err  output  1  sticky load-framing error flag.
REQ-012 in_valid / in_ready  input / output  1 each  lookup request handshake.
REQ-013 in_data  input  IN_BITS  lookup address.
REQ-014 out_valid / out_ready  output / input  1 each  lookup result handshake.
REQ-015 out_data  output  OUT_BITS  table entry at the accepted address.

Function
REQ-016 The FSM SHALL have three states: EMPTY, LOAD and RUN.
REQ-017 A load transfer SHALL occur when cfg_valid and cfg_ready are both high; it writes cfg_data to table[wptr] and increments wptr.
REQ-018 The first transfer in EMPTY SHALL write address 0 and move the FSM to LOAD (or straight to RUN when DEPTH=1 and cfg_last is high).
REQ-019 A transfer with wptr = DEPTH-1 and cfg_last=1 SHALL move the FSM to RUN, reset wptr to 0 and raise cfg_done on the next cycle.
REQ-020 Framing mismatch (cfg_last=1 with wptr<DEPTH-1, or cfg_last=0 with wptr=DEPTH-1) SHALL set cfg_err, reset wptr to 0 and return the FSM to EMPTY.
REQ-021 cfg_ready SHALL be low in RUN; cfg_valid in RUN SHALL be ignored.
REQ-022 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready).
REQ-023 Lookup latency SHALL be one cycle: a handshake in cycle N presents table[in_data] on out_data with out_valid=1 in cycle N+1.
REQ-024 out_valid and out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 A simultaneous output accept and new input accept SHALL sustain one result per cycle with no bubble.
REQ-026 cfg_clear SHALL win over every simultaneous event: next cycle state=EMPTY, wptr=0, out_valid=0, cfg_done=0; in-flight results are dropped; cfg_err is unchanged.
REQ-027 Table contents SHALL be undefined after clear; lookups are impossible until the next complete load.
REQ-028 cfg_err SHALL clear only on rst or on the first accepted entry of a new load.

Reset
REQ-029 On rst: state=EMPTY, wptr=0, cfg_done=0, cfg_err=0, out_valid=0, out_data=0; table storage is not reset.
REQ-030 rst asserted mid-load or mid-lookup SHALL abandon the operation with the same result as REQ-029 on the next cycle.

Configuration
REQ-031 With macro LUT_NEURON_CFG_READBACK_EN defined, ports rb_addr (input, IN_BITS) and rb_data (output, OUT_BITS) SHALL exist, and rb_data SHALL register table[rb_addr] every cycle in any state (1-cycle latency, reset to 0).
REQ-032 With LUT_NEURON_CFG_READBACK_EN undefined, those ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Load 64 entries with entry i = i[1:0] and cfg_last on entry 63, then look up 6'b100010 -> out_data=2'b10 one cycle later; cfg_done=1, cfg_err=0.
REQ-034 Back-to-back lookups 0,1,2,3 with out_ready=1 -> results 0,1,2,3 on consecutive cycles; hold out_ready=0 for 3 cycles -> out_data stable and in_ready=0.
REQ-035 cfg_last on entry 10 -> cfg_err=1, state EMPTY, cfg_ready=1; a full correct reload then clears cfg_err and reaches RUN.
REQ-036 cfg_clear issued together with in_valid and a pending out_valid -> next cycle out_valid=0, in_ready=0, cfg_done=0.
REQ-037 rst asserted after 30 loaded entries -> wptr=0, EMPTY; a fresh 64-entry load succeeds.
REQ-038 With LUT_NEURON_CFG_READBACK_EN defined, rb_addr=63 after load -> rb_data=2'b11 one cycle later.
